xilly_stream_aggregator: RTL and testbench

//  Merges NUM_CH application streams into one Xillybus host-read FIFO write port, in the
//  bus_clk domain next to the Xillybus core inside the KC705 PCIe design. Channels get

---
 rtl/xilly_stream_aggregator_pkg.sv | 24 ++
 rtl/xilly_stream_aggregator_if.sv | 34 +++
 rtl/xilly_stream_aggregator_rr_arbiter.sv | 33 +++
 rtl/xilly_stream_aggregator.sv | 171 +++++++++++++++++
 tb/tb_xilly_stream_aggregator.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xilly_stream_aggregator_pkg.sv
// Shared definitions for the Xillybus stream aggregator.
//   HDR_MAGIC / TRL_MAGIC : top byte of the burst header and trailer words
//   agg_state_t           : aggregator FSM states
//   mk_frame()            : builds a 32-bit header/trailer word {magic, channel, count}
package xilly_stream_aggregator_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [7:0] TRL_MAGIC = 8'h5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BURST = 2'd2,
    TRL   = 2'd3
  } agg_state_t;

  // Header and trailer share one layout; the header always carries a zero count.
  function automatic logic [31:0] mk_frame(input logic [7:0]  magic,
                                           input logic [7:0]  ch,
                                           input logic [15:0] cnt);
    return {magic, ch, cnt};
  endfunction

endpackage

// File: rtl/xilly_stream_aggregator_if.sv
// Bus bundle between the application channels, the aggregator and the Xillybus
// host-read FIFO write port.
//   s_data     NUM_CH*DATA_W  channel payload, ch i = [i*DATA_W +: DATA_W]
//   s_valid    NUM_CH         per-channel word valid
//   s_last     NUM_CH         per-channel end-of-packet marker
//   s_ready    NUM_CH         per-channel accept (driven by the aggregator)
//   fifo_full  1              Xillybus FIFO full
//   fifo_wr_en 1              FIFO write strobe (driven by the aggregator)
//   fifo_data  DATA_W         FIFO write data (driven by the aggregator)
// modport slave is the aggregator's view; modport master is the environment's view.
interface xilly_stream_aggregator_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);

  logic [NUM_CH*DATA_W-1:0] s_data;
  logic [NUM_CH-1:0]        s_valid;
  logic [NUM_CH-1:0]        s_last;
  logic [NUM_CH-1:0]        s_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [DATA_W-1:0]        fifo_data;

  modport master (
    output s_data, s_valid, s_last, fifo_full,
    input  s_ready, fifo_wr_en, fifo_data
  );

  modport slave (
    input  s_data, s_valid, s_last, fifo_full,
    output s_ready, fifo_wr_en, fifo_data
  );

endinterface

// File: rtl/xilly_stream_aggregator_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel at or after
// ptr, wrapping from NUM_CH-1 back to 0.
//   req       in   NUM_CH  request vector
//   ptr       in   IDX_W   highest-priority channel this round
//   gnt_valid out  1       at least one request present
//   gnt_idx   out  IDX_W   granted channel (0 when gnt_valid is low)
module xilly_stream_aggregator_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx
);

  // Walk the offsets from the farthest to the nearest so the channel closest to
  // ptr is the last one written and therefore wins.
  always_comb begin
    logic [IDX_W-1:0] sel;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sel       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sel = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (req[sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/xilly_stream_aggregator.sv
// Merges NUM_CH application streams into one Xillybus host-read FIFO write port.
// Channels are served in round-robin bursts of up to MAX_BURST words; each burst is
// framed by a header {A5, ch, 0000} and a trailer {5A, ch, count}. One activity LED
// per channel stays lit for LED_HOLD cycles after the last accepted word.
//   bus_clk  in   1       sole clock
//   bus_rst  in   1       synchronous active-high reset
//   enable   in   1       allow new bursts to start
//   agg_bus  slave        channel inputs, s_ready, FIFO write port
//   busy     out  1       high in any state other than IDLE
//   led      out  NUM_CH  per-channel activity indicator
module xilly_stream_aggregator
  import xilly_stream_aggregator_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LED_HOLD  = 1048576
) (
  input  logic                      bus_clk,
  input  logic                      bus_rst,
  input  logic                      enable,
  xilly_stream_aggregator_if.slave  agg_bus,
  output logic                      busy,
  output logic [NUM_CH-1:0]         led
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int LED_W = $clog2(LED_HOLD + 1);

  agg_state_t        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic              busy_q;

  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] cur_data;
  logic              cur_valid;
  logic              cur_last;
  logic              word_accept;
  logic [CNT_W-1:0]  count_inc;

  xilly_stream_aggregator_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_arbiter (
    .req       (agg_bus.s_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign cur_data  = agg_bus.s_data[int'(grant_q) * DATA_W +: DATA_W];
  assign cur_valid = agg_bus.s_valid[grant_q];
  assign cur_last  = agg_bus.s_last[grant_q];
  assign count_inc = count_q + 1'b1;

  // Handshake outputs react to fifo_full in the same cycle so the FIFO is never
  // written while full. Header/trailer come from frame_q; payload bypasses it.
  always_comb begin
    agg_bus.s_ready    = '0;
    agg_bus.fifo_wr_en = 1'b0;
    agg_bus.fifo_data  = frame_q;
    word_accept        = 1'b0;
    case (state_q)
      HDR, TRL: begin
        agg_bus.fifo_wr_en = !agg_bus.fifo_full;
      end
      BURST: begin
        agg_bus.s_ready[grant_q] = !agg_bus.fifo_full;
        agg_bus.fifo_wr_en       = cur_valid && !agg_bus.fifo_full;
        agg_bus.fifo_data        = cur_data;
        word_accept              = cur_valid && !agg_bus.fifo_full;
      end
      default: ;
    endcase
  end

  // Next-state logic. The trailer word is prepared on the transition into TRL so
  // its count already includes the final payload word.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    frame_d  = frame_q;
    case (state_q)
      IDLE: begin
        if (enable && gnt_valid) begin
          grant_d = gnt_idx;
          frame_d = DATA_W'(mk_frame(HDR_MAGIC, 8'(gnt_idx), 16'h0000));
          state_d = HDR;
        end
      end
      HDR: begin
        if (!agg_bus.fifo_full) begin
          frame_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (word_accept) begin
          count_d = count_inc;
          if (cur_last || (count_inc == CNT_W'(MAX_BURST))) begin
            frame_d = DATA_W'(mk_frame(TRL_MAGIC, 8'(grant_q), 16'(count_inc)));
            state_d = TRL;
          end
        end
      end
      TRL: begin
        if (!agg_bus.fifo_full) begin
          rr_ptr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
          count_d  = '0;
          frame_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      frame_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      frame_q  <= frame_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign busy = busy_q;

  // Per-channel LED hold counters: reload on an accepted word, otherwise count
  // down and stick at zero.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_led
    logic [LED_W-1:0] led_cnt_q, led_cnt_d;

    always_comb begin
      if (word_accept && (grant_q == CH_W'(i))) begin
        led_cnt_d = LED_W'(LED_HOLD);
      end else if (led_cnt_q != '0) begin
        led_cnt_d = led_cnt_q - 1'b1;
      end else begin
        led_cnt_d = '0;
      end
    end

    always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
        led_cnt_q <= '0;
      end else begin
        led_cnt_q <= led_cnt_d;
      end
    end

    assign led[i] = (led_cnt_q != '0);
  end

endmodule

// File: tb/tb_xilly_stream_aggregator.sv
// Scoreboard bench for xilly_stream_aggregator (NUM_CH=4, DATA_W=32, MAX_BURST=16,
// LED_HOLD=4). Tests push hand-computed FIFO words into sb_q; an independent monitor
// pops and compares on every fifo_wr_en. Channel sources are per-channel queues of
// {last, data} that advance when valid&ready was seen before the clock edge.
module tb_xilly_stream_aggregator;

  localparam int NUM_CH = 4;

  logic       bus_clk = 1'b0;
  logic       bus_rst = 1'b1;
  logic       enable  = 1'b0;
  logic       busy;
  logic [3:0] led;

  xilly_stream_aggregator_if #(.NUM_CH(4), .DATA_W(32)) agg_if ();

  xilly_stream_aggregator #(
    .NUM_CH    (4),
    .DATA_W    (32),
    .MAX_BURST (16),
    .LED_HOLD  (4)
  ) dut (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .enable  (enable),
    .agg_bus (agg_if.slave),
    .busy    (busy),
    .led     (led)
  );

  always #5 bus_clk = ~bus_clk;

  logic [32:0] ch_q [NUM_CH][$];
  logic [31:0] sb_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  fire_s = '0;
  logic        wr_en_s = 1'b0;
  logic [31:0] wr_data_s = '0;
  bit          pending_rst = 1'b1;
  logic [3:0]  flush_mask = '0;
  bit          full_mode = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int ch, input int tag, input int i);
    return 32'hD000_0000 | 32'(ch << 20) | 32'(tag << 8) | 32'(i);
  endfunction

  task automatic send_packet(input int ch, input int n, input int tag);
    for (int i = 0; i < n; i++) ch_q[ch].push_back({(i == n - 1), word_of(ch, tag, i)});
  endtask

  task automatic expect_payload(input int ch, input int tag, input int from, input int to);
    for (int i = from; i <= to; i++) sb_q.push_back(word_of(ch, tag, i));
  endtask

  function automatic bit sources_empty();
    for (int c = 0; c < NUM_CH; c++) if (ch_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of stimulus: retire words accepted at the last edge, present the
  // next heads, then sample the handshake that the coming edge will act on.
  task automatic apply_stimulus();
    @(negedge bus_clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (fire_s[c]) void'(ch_q[c].pop_front());
      if (flush_mask[c]) ch_q[c].delete();
    end
    flush_mask = '0;
    bus_rst = pending_rst;
    agg_if.fifo_full = full_mode ? ~agg_if.fifo_full : 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q[c].size() != 0) begin
        agg_if.s_valid[c]           = 1'b1;
        agg_if.s_data[c*32 +: 32]   = ch_q[c][0][31:0];
        agg_if.s_last[c]            = ch_q[c][0][32];
      end else begin
        agg_if.s_valid[c]           = 1'b0;
        agg_if.s_data[c*32 +: 32]   = '0;
        agg_if.s_last[c]            = 1'b0;
      end
    end
    #1;
    fire_s    = agg_if.s_valid & agg_if.s_ready;
    wr_en_s   = agg_if.fifo_wr_en;
    wr_data_s = agg_if.fifo_data;
  endtask

  task automatic apply_reset();
    flush_mask  = 4'hF;
    fire_s      = '0;
    full_mode   = 1'b0;
    pending_rst = 1'b1;
    apply_stimulus();
    apply_stimulus();
    pending_rst = 1'b0;
    apply_stimulus();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      apply_stimulus();
      if (sources_empty() && busy === 1'b0 && sb_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got busy=%b pending=%0d, expected idle", name, busy, sb_q.size());
    end
    check_output({name, "_drain"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  // Scoreboard monitor, decoupled from the stimulus flow.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge bus_clk);
      #2;
      if (agg_if.fifo_wr_en === 1'b1) begin
        check_output("wr_while_full", 32'(agg_if.fifo_full), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got %h, expected no write", agg_if.fifo_data);
        end else begin
          exp = sb_q.pop_front();
          check_output("fifo_data", agg_if.fifo_data, exp);
        end
      end
    end
  end

  initial begin
    int  n;
    bit  seen;
    agg_if.s_data    = '0;
    agg_if.s_valid   = '0;
    agg_if.s_last    = '0;
    agg_if.fifo_full = 1'b0;
    enable = 1'b1;

    // Reset state
    apply_reset();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_led", 32'(led), 32'd0);
    check_output("rst_s_ready", 32'(agg_if.s_ready), 32'd0);
    check_output("rst_wr_en", 32'(agg_if.fifo_wr_en), 32'd0);
    check_output("rst_fifo_data", agg_if.fifo_data, 32'd0);

    // Test 1: reset mid-burst on ch1 after word 3
    $display("[TB] test 1: reset mid-burst");
    send_packet(0, 1, 1);
    sb_q.push_back(32'hA500_0000); expect_payload(0, 1, 0, 0); sb_q.push_back(32'h5A00_0001);
    wait_idle("t1_pre", 40);
    send_packet(1, 6, 1);
    sb_q.push_back(32'hA501_0000); expect_payload(1, 1, 0, 2);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      apply_stimulus();
      if (fire_s[1]) n++;
    end
    if (n < 3) timeout_fail("t1_word3");
    pending_rst = 1'b1;
    flush_mask  = 4'b0010;
    apply_stimulus();
    pending_rst = 1'b0;
    apply_stimulus();
    check_output("t1_busy", 32'(busy), 32'd0);
    check_output("t1_s_ready", 32'(agg_if.s_ready), 32'd0);
    check_output("t1_led", 32'(led), 32'd0);
    check_output("t1_wr_en", 32'(agg_if.fifo_wr_en), 32'd0);
    check_output("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    send_packet(3, 1, 2);
    send_packet(0, 1, 2);
    sb_q.push_back(32'hA500_0000); expect_payload(0, 2, 0, 0); sb_q.push_back(32'h5A00_0001);
    sb_q.push_back(32'hA503_0000); expect_payload(3, 2, 0, 0); sb_q.push_back(32'h5A03_0001);
    wait_idle("t1", 60);

    // Test 2: ch2 five-word packet, busy timing around the trailer
    $display("[TB] test 2: single packet on ch2");
    apply_reset();
    send_packet(2, 5, 2);
    sb_q.push_back(32'hA502_0000); expect_payload(2, 2, 0, 4); sb_q.push_back(32'h5A02_0005);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus();
      if (seen) begin
        check_output("t2_busy_after_trl", 32'(busy), 32'd0);
        break;
      end
      if (wr_en_s && wr_data_s == 32'h5A02_0005) begin
        check_output("t2_busy_at_trl", 32'(busy), 32'd1);
        seen = 1'b1;
      end
    end
    if (!seen) timeout_fail("t2_trailer");
    wait_idle("t2", 20);

    // Test 3: four channels, 20-word packets split by MAX_BURST
    $display("[TB] test 3: round robin with MAX_BURST split");
    apply_reset();
    for (int c = 0; c < NUM_CH; c++) send_packet(c, 20, 3);
    for (int c = 0; c < NUM_CH; c++) begin
      sb_q.push_back(32'hA500_0000 | 32'(c << 16));
      expect_payload(c, 3, 0, 15);
      sb_q.push_back(32'h5A00_0010 | 32'(c << 16));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      sb_q.push_back(32'hA500_0000 | 32'(c << 16));
      expect_payload(c, 3, 16, 19);
      sb_q.push_back(32'h5A00_0004 | 32'(c << 16));
    end
    wait_idle("t3", 400);

    // Test 4: fifo_full toggling during a ch0 3-word burst
    $display("[TB] test 4: fifo_full toggling");
    apply_reset();
    full_mode = 1'b1;
    send_packet(0, 3, 4);
    sb_q.push_back(32'hA500_0000); expect_payload(0, 4, 0, 2); sb_q.push_back(32'h5A00_0003);
    wait_idle("t4", 60);
    full_mode = 1'b0;

    // Test 5: enable drops mid-burst on ch3
    $display("[TB] test 5: enable drop mid-burst");
    apply_reset();
    send_packet(3, 6, 5);
    sb_q.push_back(32'hA503_0000); expect_payload(3, 5, 0, 5); sb_q.push_back(32'h5A03_0006);
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      apply_stimulus();
      if (fire_s[3]) n++;
    end
    if (n < 2) timeout_fail("t5_word2");
    enable = 1'b0;
    for (int c = 0; c < NUM_CH; c++) send_packet(c, 1, 7);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      apply_stimulus();
      if (busy === 1'b0 && ch_q[3].size() == 1) seen = 1'b1;
    end
    if (!seen) timeout_fail("t5_burst_done");
    check_output("t5_trl_done", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < 10; i++) apply_stimulus();
    check_output("t5_no_grant_busy", 32'(busy), 32'd0);
    check_output("t5_no_grant_ready", 32'(agg_if.s_ready), 32'd0);
    enable = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      sb_q.push_back(32'hA500_0000 | 32'(c << 16));
      expect_payload(c, 7, 0, 0);
      sb_q.push_back(32'h5A00_0001 | 32'(c << 16));
    end
    wait_idle("t5", 100);

    // Test 6: LED hold of 4 cycles after a single word on ch1
    $display("[TB] test 6: LED hold");
    apply_reset();
    send_packet(1, 1, 6);
    sb_q.push_back(32'hA501_0000); expect_payload(1, 6, 0, 0); sb_q.push_back(32'h5A01_0001);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      apply_stimulus();
      if (fire_s[1]) seen = 1'b1;
    end
    if (!seen) timeout_fail("t6_accept");
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus();
      check_output($sformatf("t6_led1_cycle%0d", k), 32'(led[1]), (k <= 4) ? 32'd1 : 32'd0);
      if (k == 1) check_output("t6_led_others", 32'(led & 4'b1101), 32'd0);
    end
    wait_idle("t6", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
